// File: rtl/com_fifo_fwft_rd.sv
`default_nettype none
// ============================================================================
//  Module   : com_fifo_fwft_rd
//  Brief    : Read-side output stage for the common synchronous FIFO. Issues
//             reads against the pointer controller, captures 1-cycle-latency
//             RAM data into a 2-entry buffer and presents a first-word-fall-
//             through valid/ready stream at one word per cycle.
//  Options  : COM_FIFO_FWFT_RD_ZERO_DATA_EN - force m_data to 0 while m_valid
//             is low (otherwise the stale head entry is visible).
//  Revision : 1.0 - initial release
// ============================================================================
module com_fifo_fwft_rd #(
   parameter int DW      = 32,
   parameter int RAM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          rd_empty,
   output logic          rd_en,
   input  logic [DW-1:0] ram_rdata,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic [1:0]    buf_cnt
);

   // Only a single-cycle RAM is supported; any other latency breaks the
   // credit accounting, which reserves exactly one slot per read in flight.
   generate
      if (RAM_LAT != 1) begin : g_ram_lat_bad
         $error("com_fifo_fwft_rd: RAM_LAT must be 1");
      end
   endgenerate

   logic          inflight_q, inflight_d;
   logic          head_q,     head_d;
   logic [1:0]    buf_cnt_q,  buf_cnt_d;
   logic [DW-1:0] mem0_q,     mem0_d;
   logic [DW-1:0] mem1_q,     mem1_d;

   logic          pop;
   logic          push;
   logic          tail;
   logic [2:0]    occ_next;
   logic [DW-1:0] head_data;

   assign m_valid = (buf_cnt_q != 2'd0);
   assign buf_cnt = buf_cnt_q;
   assign pop     = m_valid && m_ready;
   assign push    = inflight_q && !clear;
   // Tail slot is head + count (mod 2); with a full buffer and a pop this
   // lands on the slot being vacated by the head.
   assign tail    = head_q ^ buf_cnt_q[0];

   // Occupancy after this edge if no new read were issued; a read may be
   // issued only while that leaves room for its returning word.
   assign occ_next = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_en    = !rd_empty && !clear && (occ_next < 3'd2);

   assign head_data = head_q ? mem1_q : mem0_q;

`ifdef COM_FIFO_FWFT_RD_ZERO_DATA_EN
   assign m_data = head_data & {DW{m_valid}};
`else
   assign m_data = head_data;
`endif

   // Next-state: buffer bookkeeping, read tracking and tail write.
   always_comb begin
      inflight_d = inflight_q;
      head_d     = head_q;
      buf_cnt_d  = buf_cnt_q;
      mem0_d     = mem0_q;
      mem1_d     = mem1_q;
      if (clear) begin
         // Any word returning from a read issued last cycle is dropped.
         inflight_d = 1'b0;
         head_d     = 1'b0;
         buf_cnt_d  = 2'd0;
      end else begin
         inflight_d = rd_en;
         head_d     = head_q ^ pop;
         buf_cnt_d  = buf_cnt_q + {1'b0, push} - {1'b0, pop};
         if (push) begin
            if (tail) begin
               mem1_d = ram_rdata;
            end else begin
               mem0_d = ram_rdata;
            end
         end
      end
   end

   // State registers, asynchronously reset to an empty buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         head_q     <= 1'b0;
         buf_cnt_q  <= 2'd0;
         mem0_q     <= '0;
         mem1_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         head_q     <= head_d;
         buf_cnt_q  <= buf_cnt_d;
         mem0_q     <= mem0_d;
         mem1_q     <= mem1_d;
      end
   end

   // Lite protocol checks: no overflow of the buffer, no read of an empty FIFO.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         a_no_overflow : assert (!(push && (buf_cnt_q == 2'd2) && !pop));
         a_no_empty_rd : assert (!(rd_en && rd_empty));
      end
   end

endmodule
`default_nettype wire

// File: doc/com_fifo_fwft_rd.md
# com_fifo_fwft_rd

Read-side output stage for the common synchronous FIFO. It sits downstream of the FIFO pointer controller and its 1-cycle-latency storage RAM. It issues reads from the controller's `rd_en`/`rd_empty` side and captures RAM read data into a 2-entry output buffer. It presents a first-word-fall-through valid/ready stream to the consumer at full throughput, one word per cycle.

## Interface
Parameters:
- `DW`, 32, data width of RAM read data and output stream.
- `RAM_LAT`, 1, RAM read latency in cycles; only 1 is supported, and any other value is an elaboration-time parameter assertion.

Ports:
- `clk`, input, 1, clock.
- `rst_n`, input, 1, reset; asynchronous, active-low.
- `clear`, input, 1, synchronous flush; driven with the same signal as the controller's `clear`.
- `rd_empty`, input, 1, controller empty flag.
- `rd_en`, output, 1, controller read strobe; the RAM is read at the controller's current `rd_addr` in the same cycle.
- `ram_rdata`, input, DW, RAM read data; valid 1 cycle after `rd_en`.
- `m_valid`, output, 1, output word valid.
- `m_ready`, input, 1, consumer accepts the word.
- `m_data`, output, DW, output word (buffer head).
- `buf_cnt`, output, 2, words held in the output buffer (0..2).

## Operation
Internal state:
- `inflight`: 1 bit, set in cycle t+1 when `rd_en` was high in cycle t.
- Two DW-bit entries with a 1-bit head pointer.
- `buf_cnt`.

Rules:
- **Pop:** `pop = m_valid && m_ready`.
- **Push:** `push = inflight && !clear`. `ram_rdata` is written to the tail entry (head+buf_cnt, mod 2).
- **Credit:** `rd_en = !rd_empty && !clear && (buf_cnt + inflight - pop) < 2`. Evaluate this in 3-bit unsigned arithmetic; it is combinational and never exceeds 2.
- **Invariant:** `buf_cnt + inflight <= 2` at every clock edge.
- **Simultaneous push and pop:** `buf_cnt` is unchanged, the head advances, and the new word goes to the freed slot. Order is strictly FIFO.
- **Outputs:** `m_valid = (buf_cnt != 0)` and `m_data` = head entry; both come directly from registers, with no combinational path from `ram_rdata`.
- **Clear:** `buf_cnt`, head and `inflight` are zeroed on the next edge. Data returning from a read issued the cycle before `clear` is discarded. `rd_en` is low while `clear` is high.
- **Reset:** `buf_cnt`=0, head=0, `inflight`=0 and entries=0. After reset, `m_valid`=0 and `m_data`=0. `rd_en`=0 while `rd_empty`=1, which is the controller reset state.
- **`m_valid` low:** `m_ready` is ignored.
- **Hold rule:** once `m_valid` is asserted, `m_valid` and `m_data` hold until the pop, except on `clear` or reset.

## Timing
- **First-word latency:** `rd_empty` falls in cycle t. Then `rd_en`=1 in cycle t, `ram_rdata` is valid in t+1, and `m_valid`=1 with the word on `m_data` in t+2.
- **Streaming:** with `m_ready` held at 1 and the FIFO non-empty, `rd_en` is high every cycle and `m_valid` is high every cycle after the initial 2-cycle fill.
- **Backpressure:** `m_ready`=0 with `buf_cnt`=2 gives `rd_en`=0. On the cycle `m_ready` returns, the credit rule raises `rd_en` in that same cycle.
- **Draining:** `rd_empty`=1 leaves `rd_en`=0. Buffered words still drain at one per cycle.

## Configuration
Macro `COM_FIFO_FWFT_RD_ZERO_DATA_EN`:
- **Defined:** `m_data` is forced to 0 whenever `m_valid`=0, via an AND mask after the head mux.
- **Not defined:** `m_data` shows the head entry's stale contents when `m_valid`=0, which saves area.

The following behaviour is identical in both builds:
- All valid-cycle data.
- Lite signal assertions:
  - overflow: `push` with `buf_cnt`=2 and no pop;
  - `rd_en` while `rd_empty`=1.

## Test plan
1. **Reset:** apply reset with `rd_empty`=1 → `m_valid`=0, `m_data`=0, `buf_cnt`=0, `rd_en`=0 for 10 cycles.
2. **Single word:** write 0xA5 to the FIFO, `m_ready`=0 → `rd_en` pulses once. Two cycles later `m_valid`=1, `m_data`=0xA5, `buf_cnt`=1; this holds until `m_ready`=1, then `m_valid`=0.
3. **Streaming:** preload words 1..8, `m_ready`=1 → `m_data` shows 1..8 on 8 consecutive cycles, and `rd_en` is high for 8 consecutive cycles.
4. **Backpressure:** preload 1..4, `m_ready`=0 → after 2 reads `buf_cnt`=2, `inflight`=0, and `rd_en` stays 0. With `m_ready`=1 the output is 1,2,3,4 in order with no loss or duplication.
5. **Clear with read in flight:** preload 1..4, assert `clear` the cycle after the first `rd_en` → next cycle `m_valid`=0 and `buf_cnt`=0. Word 1 never appears, and no `rd_en` fires until new writes arrive.
6. **Random soak:** random `m_ready` against random writes for 10k cycles → scoreboard order is exact and `buf_cnt+inflight` never exceeds 2. Run once with the macro defined (`m_data`=0 whenever `m_valid`=0) and once without it.
